analisa_arb: RTL
================

# analisa_arb

Round-robin controller that shares one 2-bit serial pattern-analyzer FSM among NREQ requesters. It grants one requester at a time and clears the shared FSM. It then shifts the requester's NBITS-bit word into the FSM's serial input `w`, counts the cycles where the FSM output `y` is high, and returns the hit count tagged with the requester index. It sits between the requester blocks and the single analyzer instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, bits per word shifted into the analyzer
- CNTW, 4, width of hit counter
- ck  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester, level
- data  in  NREQ*NBITS  word of requester i at [i*NBITS +: NBITS]
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- w  out  1  serial bit to shared analyzer
- fsm_rst  out  1  active-high clear to shared analyzer
- y  in  1  shared analyzer output
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, result valid
- done_id  out  $clog2(NREQ)  index of requester just served
- hits  out  CNTW  hit count, held until next done

## Operation
- States: IDLE, CLR, SHIFT, WAIT, DONE.
- IDLE, any req high:
  - Choose a winner by scanning indices from last+1 upward with wrap-around.
  - Load the winner's word into the shift register.
  - Assert the winner's gnt bit and latch its index.
  - Go to CLR.
- IDLE, no req: stay in IDLE.
- CLR, 1 cycle:
  - fsm_rst=1, hits internal count cleared.
  - Go to SHIFT.
- SHIFT, NBITS cycles:
  - w = shift register MSB, shifting left one bit per cycle; bit counter runs 0..NBITS-1.
  - y is sampled in every SHIFT cycle except the first; a sample of 1 increments the count.
  - After bit NBITS-1, go to WAIT.
- WAIT, 1 cycle:
  - w=0; y is sampled for the last bit.
  - Go to DONE.
  - Total y samples per transaction = NBITS.
- DONE, 1 cycle:
  - done=1; hits and done_id are updated.
  - gnt is cleared; last is set to the served index.
  - Go to IDLE.
- Count arithmetic: the count saturates at 2^CNTW-1 and does not wrap.
- req deasserted after grant is ignored; the transaction completes and done still pulses.
- req changes on other lines during a transaction have no effect until IDLE.
- data is sampled only at grant; later changes are ignored.

## Timing
- Reset values:
  - state IDLE; gnt=0, w=0, fsm_rst=0, busy=0, done=0, done_id=0, hits=0.
  - last=NREQ-1, so requester 0 wins first.
- rst low mid-transaction: all outputs go to reset values immediately; the transaction is abandoned with no done.
- Grant latency: req high in IDLE at edge k → gnt high after edge k.
- Done latency: relative to the first gnt cycle, CLR is cycle 1, SHIFT cycles 2..NBITS+1, WAIT cycle NBITS+2, DONE cycle NBITS+3.
- Back-to-back: at least one IDLE cycle between DONE and the next CLR. Throughput is one word per NBITS+4 cycles.
- The analyzer is assumed to register w on ck, so y for bit b is valid one cycle after bit b is on w.

## Configuration
- ANALISA_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index always wins; last is not used.
- ANALISA_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset: pull rst low during SHIFT → gnt=0, busy=0, w=0 immediately, with no done. After release, req[2]=1 → gnt=4'b0100 after the next edge.
- Single request: NREQ=4, NBITS=8, data[1]=8'hA5, bench y = w delayed one cycle, req[1]=1.
  - w sequence 1,0,1,0,0,1,0,1.
  - done high exactly 11 cycles after the first gnt cycle, with done_id=1 and hits=4.
- Round-robin: req=4'b1111 held → grant order 0,1,2,3,0, each grant lasting 11 cycles, with ≥1 IDLE cycle between grants. With ANALISA_ARB_FIXED_PRIO_EN defined → every grant is 0.
- Saturation: CNTW=2, y held 1 → hits=3, not 0.
- Withdrawn request: req[3] pulsed for 1 cycle at IDLE → full transaction runs and done pulses with done_id=3. The data change after grant does not affect the w sequence.

Source files
------------

// File: rtl/analisa_arb.sv
// analisa_arb
// -----------
// Shares one serial 2-bit pattern-analyzer FSM among NREQ requesters. One
// requester is granted at a time. The arbiter clears the analyzer and shifts
// the requester's NBITS-bit word MSB first into the analyzer input w. It
// counts the cycles where the analyzer output y is high, then returns the
// saturating hit count tagged with the requester index.
//
// Handshake: req[i] is a level request that is only looked at in IDLE. Once
// granted, gnt[i] stays high for the whole transaction (CLR, SHIFT, WAIT and
// DONE) whatever req does. The word is captured at grant time. done pulses
// for one cycle with done_id/hits valid, and hits/done_id hold until the
// next done.
//
// Build option: define ANALISA_ARB_FIXED_PRIO_EN for fixed priority (the
// lowest asserted index always wins). The default is round-robin starting
// after the last served index.
//
// Ports
//   ck        in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   req       in   [NREQ]        level request per requester
//   data      in   [NREQ*NBITS]  word of requester i at [i*NBITS +: NBITS]
//   gnt       out  [NREQ]        one-hot grant, held through the transaction
//   w         out  serial bit to the shared analyzer
//   fsm_rst   out  active-high clear to the shared analyzer
//   y         in   shared analyzer output
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-cycle result pulse
//   done_id   out  [$clog2(NREQ)] index of the requester just served
//   hits      out  [CNTW]        saturating hit count
//   state_dbg out  [3]           current FSM state (debug observation)

module analisa_arb #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int CNTW  = 4,
    localparam int IDW  = $clog2(NREQ),
    localparam int BCW  = $clog2(NBITS + 1)
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  w,
    output logic                  fsm_rst,
    input  logic                  y,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [CNTW-1:0]       hits,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [CNTW-1:0]  hits_q, hits_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [CNTW-1:0]  cnt_inc;

`ifdef ANALISA_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the final assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] cand;

    // Candidates are last+1 .. last+NREQ (mod NREQ). Scanning the offsets
    // downward lets the nearest candidate after last win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDW'((int'(last_q) + off) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_DONE) begin
            last_d = idx_q;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            last_q <= IDW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Saturating increment: the count sticks at all-ones.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        done_id_d = done_id_q;
        hits_d    = hits_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    sr_d           = data[win_idx*NBITS +: NBITS];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    idx_d          = win_idx;
                    state_d        = S_CLR;
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sr_d = sr_q << 1;
                // The analyzer registers w, so y in this cycle belongs to
                // the previous bit. The first SHIFT cycle has no bit behind
                // it yet.
                if ((bit_q != '0) && y) begin
                    cnt_d = cnt_inc;
                end
                if (bit_q == BCW'(NBITS - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    bit_d = bit_q + BCW'(1);
                end
            end
            S_WAIT: begin
                // Last bit's y arrives here. Fold it straight into the
                // published result so hits is valid during DONE.
                if (y) begin
                    cnt_d  = cnt_inc;
                    hits_d = cnt_inc;
                end else begin
                    hits_d = cnt_q;
                end
                done_id_d = idx_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            done_id_q <= '0;
            hits_q    <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            done_id_q <= done_id_d;
            hits_q    <= hits_d;
        end
    end

    assign gnt       = gnt_q;
    assign w         = (state_q == S_SHIFT) ? sr_q[NBITS-1] : 1'b0;
    assign fsm_rst   = (state_q == S_CLR);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign done_id   = done_id_q;
    assign hits      = hits_q;
    assign state_dbg = state_q;

endmodule
